// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logical/arithmetic/rotate shifter: one register per log2 shift level,
// valid/ready flow control with a whole-pipe stall, tag sideband and carry/zero/error flags.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  typedef logic [WIDTH-1:0] word_t;

  function automatic word_t bit_rev(input word_t x);
    word_t r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // LSL, ASL and ROL run through the right-shift hardware on bit-reversed data.
  function automatic logic is_left(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b011) || (op == 3'b100);
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Right shift by sh; the MSB returned is the last bit shifted out.
  function automatic logic [WIDTH:0] level_shift(input word_t x, input logic [2:0] op,
                                                 input int sh);
    word_t r;
    logic signed [WIDTH-1:0] xs;
    xs = $signed(x);
    case (op)
      3'b010:         r = word_t'(xs >>> sh);
      3'b100, 3'b101: r = (x >> sh) | (x << (WIDTH - sh));
      default:        r = x >> sh;
    endcase
    return {x[sh-1], r};
  endfunction

  logic             vld_q   [SHW];
  word_t            data_q  [SHW];
  logic             carry_q [SHW];
  logic             err_q   [SHW];
  logic [TAG_W-1:0] tag_q   [SHW];
  logic [SHW-1:0]   amt_q   [SHW-1];
  logic [2:0]       op_q    [SHW-1];
  logic             zero_q;

  logic             src_vld   [SHW];
  word_t            src_data  [SHW];
  logic             src_carry [SHW];
  logic             src_err   [SHW];
  logic [TAG_W-1:0] src_tag   [SHW];
  logic [SHW-1:0]   src_amt   [SHW];
  logic [2:0]       src_op    [SHW];

  word_t            data_d  [SHW];
  logic             carry_d [SHW];
  logic             zero_d;
  logic [WIDTH:0]   lvl;
  logic             advance;

  assign advance  = ~vld_q[SHW-1] | out_ready;
  assign in_ready = advance;

  always_comb begin
    lvl          = '0;
    zero_d       = 1'b0;
    src_vld[0]   = in_valid;
    src_data[0]  = is_left(in_op) ? bit_rev(in_data) : in_data;
    src_carry[0] = 1'b0;
    src_err[0]   = is_illegal(in_op);
    src_tag[0]   = in_tag;
    src_amt[0]   = in_amt;
    src_op[0]    = in_op;
    for (int k = 1; k < SHW; k++) begin
      src_vld[k]   = vld_q[k-1];
      src_data[k]  = data_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_err[k]   = err_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_op[k]    = op_q[k-1];
    end
    // Illegal ops never shift, which leaves data unchanged and carry at 0.
    for (int k = 0; k < SHW; k++) begin
      lvl = level_shift(src_data[k], src_op[k], 1 << k);
      if (src_amt[k][k] && !src_err[k]) begin
        data_d[k]  = lvl[WIDTH-1:0];
        carry_d[k] = lvl[WIDTH];
      end else begin
        data_d[k]  = src_data[k];
        carry_d[k] = src_carry[k];
      end
    end
    if (is_left(src_op[SHW-1])) data_d[SHW-1] = bit_rev(data_d[SHW-1]);
    zero_d = (data_d[SHW-1] == '0);
  end

  // Stage boundaries: register k holds the result of shift level k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]   <= 1'b0;
        data_q[k]  <= '0;
        carry_q[k] <= 1'b0;
        err_q[k]   <= 1'b0;
        tag_q[k]   <= '0;
      end
      for (int k = 0; k < SHW-1; k++) begin
        amt_q[k] <= '0;
        op_q[k]  <= '0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]   <= src_vld[k];
        data_q[k]  <= data_d[k];
        carry_q[k] <= carry_d[k];
        err_q[k]   <= src_err[k];
        tag_q[k]   <= src_tag[k];
      end
      for (int k = 0; k < SHW-1; k++) begin
        amt_q[k] <= src_amt[k];
        op_q[k]  <= src_op[k];
      end
      zero_q <= zero_d;
    end
  end

  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_carry = carry_q[SHW-1];
  assign out_err   = err_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];
  assign out_zero  = zero_q;

endmodule
